// File: rtl/zmips_pkg.sv
// Shared encodings for the zmips single-cycle core: MIPS-I opcode/funct values
// and the control enums produced by the decoder.
package zmips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic {EXT_SIGN, EXT_ZERO} ext_e;

  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG} pc_sel_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_e;

endpackage

// File: rtl/zmips_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired to zero.
module zmips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] regs [32];

  // Entry 0 is never written, so it holds the cleared value forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs_data = (rs_addr == 5'd0) ? 32'h0 : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'h0 : regs[rt_addr];

endmodule

// File: rtl/zmips_cpu.sv
// Single-cycle MIPS-I subset core: fetch, decode, execute and commit all within one clock.
module zmips_cpu
  import zmips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data,
  output logic [31:0] i_addr,
  output logic [31:0] d_addr,
  output logic [31:0] d_data_o,
  input  logic [31:0] d_data_i,
  output logic        d_wr,
  output logic        d_rd
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target;

  assign opcode = i_data[31:26];
  assign rs     = i_data[25:21];
  assign rt     = i_data[20:16];
  assign rd     = i_data[15:11];
  assign shamt  = i_data[10:6];
  assign funct  = i_data[5:0];
  assign imm16  = i_data[15:0];
  assign target = i_data[25:0];

  // PC is held in word units so the fetch address can never be misaligned.
  logic [29:0] pc_w, pc_plus4_w, next_pc_w;
  logic [31:0] rs_val, rt_val, simm, imm_ext, alu_b, alu_res, wb_data;

  alu_op_e alu_op;
  ext_e    ext_mode;
  pc_sel_e pc_sel;
  wb_sel_e wb_sel;
  logic    use_imm, reg_we, mem_rd, mem_wr;
  logic [4:0] wr_reg;

  always_comb begin
    alu_op   = ALU_ADD;
    ext_mode = EXT_SIGN;
    use_imm  = 1'b0;
    reg_we   = 1'b0;
    wr_reg   = rt;
    wb_sel   = WB_ALU;
    pc_sel   = PC_SEQ;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wr_reg = rd;
        reg_we = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:         alu_op = ALU_AND;
          F_OR:          alu_op = ALU_OR;
          F_XOR:         alu_op = ALU_XOR;
          F_NOR:         alu_op = ALU_NOR;
          F_SLT:         alu_op = ALU_SLT;
          F_SLTU:        alu_op = ALU_SLTU;
          F_SLL:         alu_op = ALU_SLL;
          F_SRL:         alu_op = ALU_SRL;
          F_SRA:         alu_op = ALU_SRA;
          F_JR: begin
            reg_we = 1'b0;
            pc_sel = PC_REG;
          end
          default:       reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin use_imm = 1'b1; reg_we = 1'b1; end
      OP_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; reg_we = 1'b1; end
      OP_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; reg_we = 1'b1; end
      OP_ANDI:  begin alu_op = ALU_AND; ext_mode = EXT_ZERO; use_imm = 1'b1; reg_we = 1'b1; end
      OP_ORI:   begin alu_op = ALU_OR;  ext_mode = EXT_ZERO; use_imm = 1'b1; reg_we = 1'b1; end
      OP_XORI:  begin alu_op = ALU_XOR; ext_mode = EXT_ZERO; use_imm = 1'b1; reg_we = 1'b1; end
      OP_LUI:   begin alu_op = ALU_LUI; reg_we = 1'b1; end
      OP_LW:    begin use_imm = 1'b1; reg_we = 1'b1; wb_sel = WB_MEM; mem_rd = 1'b1; end
      OP_SW:    mem_wr = 1'b1;
      OP_BEQ:   if (rs_val == rt_val) pc_sel = PC_BRANCH;
      OP_BNE:   if (rs_val != rt_val) pc_sel = PC_BRANCH;
      OP_J:     pc_sel = PC_JUMP;
      OP_JAL: begin
        pc_sel = PC_JUMP;
        reg_we = 1'b1;
        wr_reg = 5'd31;
        wb_sel = WB_LINK;
      end
      default: ;
    endcase
  end

  assign simm    = {{16{imm16[15]}}, imm16};
  assign imm_ext = (ext_mode == EXT_ZERO) ? {16'h0000, imm16} : simm;
  assign alu_b   = use_imm ? imm_ext : rt_val;

  // Shifts always take rt as the shifted operand and shamt as the distance.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = rs_val + alu_b;
      ALU_SUB:  alu_res = rs_val - alu_b;
      ALU_AND:  alu_res = rs_val & alu_b;
      ALU_OR:   alu_res = rs_val | alu_b;
      ALU_XOR:  alu_res = rs_val ^ alu_b;
      ALU_NOR:  alu_res = ~(rs_val | alu_b);
      ALU_SLT:  alu_res = {31'b0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'b0, rs_val < alu_b};
      ALU_SLL:  alu_res = rt_val << shamt;
      ALU_SRL:  alu_res = rt_val >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(rt_val) >>> shamt);
      ALU_LUI:  alu_res = {imm16, 16'h0000};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    wb_data = alu_res;
    case (wb_sel)
      WB_MEM:  wb_data = d_data_i;
      WB_LINK: wb_data = {pc_plus4_w, 2'b00};
      default: wb_data = alu_res;
    endcase
  end

  assign pc_plus4_w = pc_w + 30'd1;

  always_comb begin
    next_pc_w = pc_plus4_w;
    case (pc_sel)
      PC_BRANCH: next_pc_w = pc_plus4_w + {{14{imm16[15]}}, imm16};
      PC_JUMP:   next_pc_w = {pc_plus4_w[29:26], target};
      PC_REG:    next_pc_w = rs_val[31:2];
      default:   next_pc_w = pc_plus4_w;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_w <= RESET_PC[31:2];
    else     pc_w <= next_pc_w;
  end

  zmips_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (reg_we),
    .wr_addr (wr_reg),
    .wr_data (wb_data),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_val),
    .rt_data (rt_val)
  );

  assign i_addr   = {pc_w, 2'b00};
  assign d_addr   = rs_val + simm;
  assign d_data_o = rt_val;
  // Strobes are gated by reset so a held-in-reset core never touches memory.
  assign d_wr     = mem_wr & ~rst;
  assign d_rd     = mem_rd & ~rst;

endmodule

// File: tb/tb_zmips_cpu.sv
// Lockstep bench for zmips_cpu: an ISA-level interpreter predicts fetch address and bus outputs every cycle.
module tb_zmips_cpu;

  logic        clk, rst;
  logic [31:0] i_data, i_addr, d_addr, d_data_o, d_data_i;
  logic        d_wr, d_rd;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] m_mem [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] ADDIU = 6'h09, LUI = 6'h0F, ORI = 6'h0D, LW = 6'h23, SW = 6'h2B;
  localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, JAL = 6'h03;

  logic [5:0] r_fns  [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h20};
  logic [5:0] i_ops  [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [5:0] bad_ops[6]  = '{6'h01, 6'h06, 6'h07, 6'h20, 6'h28, 6'h3F};

  zmips_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_data   (i_data),
    .i_addr   (i_addr),
    .d_addr   (d_addr),
    .d_data_o (d_data_o),
    .d_data_i (d_data_i),
    .d_wr     (d_wr),
    .d_rd     (d_rd)
  );

  assign i_data   = imem[i_addr[9:2]];
  assign d_data_i = dmem[d_addr[9:2]];

  always @(negedge clk) if (d_wr) dmem[d_addr[9:2]] <= d_data_o;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Executes the instruction at m_pc on the architectural model and returns the expected bus activity.
  task automatic model_exec(output logic e_rd, output logic e_wr,
                            output logic [31:0] e_addr, output logic [31:0] e_dout);
    logic [31:0] ins, a, b, simm, zimm, res, npc;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, wreg;
    logic        we;
    ins  = imem[m_pc[9:2]];
    op   = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh   = ins[10:6];  fn = ins[5:0];
    a    = m_regs[rs];
    b    = m_regs[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0000, ins[15:0]};
    npc  = m_pc + 32'd4;
    e_addr = a + simm;
    e_dout = b;
    e_rd = 1'b0; e_wr = 1'b0;
    we = 1'b0; wreg = rt; res = 32'h0;
    case (op)
      6'h00: begin
        wreg = rd;
        we   = 1'b1;
        case (fn)
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: res = (a < b) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = $signed(b) >>> sh;
          6'h08: begin we = 1'b0; npc = {a[31:2], 2'b00}; end
          default: we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin res = a + simm; we = 1'b1; end
      6'h0A: begin res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; we = 1'b1; end
      6'h0B: begin res = (a < simm) ? 32'd1 : 32'd0; we = 1'b1; end
      6'h0C: begin res = a & zimm; we = 1'b1; end
      6'h0D: begin res = a | zimm; we = 1'b1; end
      6'h0E: begin res = a ^ zimm; we = 1'b1; end
      6'h0F: begin res = {ins[15:0], 16'h0000}; we = 1'b1; end
      6'h23: begin res = m_mem[e_addr[9:2]]; e_rd = 1'b1; we = 1'b1; end
      6'h2B: begin e_wr = 1'b1; m_mem[e_addr[9:2]] = b; end
      6'h04: if (a == b) npc = m_pc + 32'd4 + (simm << 2);
      6'h05: if (a != b) npc = m_pc + 32'd4 + (simm << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        res  = m_pc + 32'd4;
        npc  = {npc[31:28], ins[25:0], 2'b00};
        we   = 1'b1;
        wreg = 5'd31;
      end
      default: ;
    endcase
    if (we && wreg != 5'd0) m_regs[wreg] = res;
    m_pc = npc;
  endtask

  // Runs n cycles, comparing every DUT output against the model each cycle.
  task automatic applyStimulus(input int n);
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_dout;
    for (int k = 0; k < n; k++) begin
      checkOutput("i_addr", i_addr, m_pc);
      model_exec(e_rd, e_wr, e_addr, e_dout);
      checkOutput("d_rd", {31'b0, d_rd}, {31'b0, e_rd});
      checkOutput("d_wr", {31'b0, d_wr}, {31'b0, e_wr});
      checkOutput("d_addr", d_addr, e_addr);
      checkOutput("d_data_o", d_data_o, e_dout);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic reset_assert();
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_i_addr", i_addr, 32'h0);
    checkOutput("rst_d_wr", {31'b0, d_wr}, 32'h0);
    checkOutput("rst_d_rd", {31'b0, d_rd}, 32'h0);
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #2;
    checkOutput("held_i_addr", i_addr, 32'h0);
    #1 rst = 1'b0;
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    for (int i = 0; i < 256; i++) begin
      dmem[i]  = $urandom;
      m_mem[i] = dmem[i];
      imem[i]  = 32'h0;
    end

    // Strobes must stay low under reset even with a store or load being presented.
    imem[0] = enc_i(SW, 5'd0, 5'd1, 16'h0);
    #2;
    checkOutput("rst_i_addr", i_addr, 32'h0);
    checkOutput("rst_d_wr_sw", {31'b0, d_wr}, 32'h0);
    imem[0] = enc_i(LW, 5'd0, 5'd2, 16'h4);
    #10;
    checkOutput("rst_d_rd_lw", {31'b0, d_rd}, 32'h0);

    // ALU program, results read back through stores.
    imem[0] = enc_i(ADDIU, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(ADDIU, 5'd0, 5'd2, 16'hFFFD);
    imem[2] = enc_r(6'h21, 5'd1, 5'd2, 5'd3, 5'd0);
    imem[3] = enc_r(6'h2A, 5'd2, 5'd1, 5'd4, 5'd0);
    imem[4] = enc_r(6'h2B, 5'd2, 5'd1, 5'd5, 5'd0);
    imem[5] = enc_r(6'h03, 5'd0, 5'd2, 5'd6, 5'd1);
    for (int k = 0; k < 4; k++) imem[6+k] = enc_i(SW, 5'd0, 5'(3+k), 16'(4*k));
    #13 rst = 1'b0;
    #1;
    applyStimulus(10);

    // Load/store round trip.
    reset_assert();
    imem[0] = enc_i(LUI, 5'd0, 5'd1, 16'h1234);
    imem[1] = enc_i(ORI, 5'd1, 5'd1, 16'h5678);
    imem[2] = enc_i(SW, 5'd0, 5'd1, 16'd8);
    imem[3] = enc_i(LW, 5'd0, 5'd2, 16'd8);
    imem[4] = enc_i(SW, 5'd0, 5'd2, 16'd16);
    reset_release();
    applyStimulus(5);

    // Branches: taken forward, not taken, and a self-loop.
    reset_assert();
    imem[4] = enc_i(BEQ, 5'd0, 5'd0, 16'd2);
    imem[7] = enc_i(BNE, 5'd0, 5'd0, 16'd2);
    imem[8] = enc_i(BEQ, 5'd0, 5'd0, 16'hFFFF);
    reset_release();
    applyStimulus(9);

    // jal / jr pair, link value observed through a store.
    reset_assert();
    imem[2]  = {JAL, 26'h40};
    imem[64] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
    imem[3]  = enc_i(SW, 5'd0, 5'd31, 16'h30);
    reset_release();
    applyStimulus(6);

    // Writes to $0 are dropped; unknown opcode behaves as a NOP.
    reset_assert();
    imem[0] = enc_i(ADDIU, 5'd0, 5'd0, 16'd7);
    imem[1] = enc_i(SW, 5'd0, 5'd0, 16'h20);
    imem[2] = {6'h3F, 26'h3FF_FFFF};
    imem[3] = enc_i(SW, 5'd0, 5'd0, 16'h24);
    reset_release();
    applyStimulus(5);

    // Random program seeded with distinct register values.
    reset_assert();
    for (int k = 1; k < 32; k++) imem[k-1] = enc_i(ADDIU, 5'd0, 5'(k), 16'($urandom));
    for (int k = 31; k < 200; k++) begin
      logic [4:0] rs, rt, rd;
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0, 1, 2: imem[k] = enc_r(r_fns[$urandom_range(0, 13)], rs, rt, rd, 5'($urandom));
        3, 4, 5: imem[k] = enc_i(i_ops[$urandom_range(0, 7)], rs, rt, 16'($urandom));
        6:       imem[k] = enc_i(LW, 5'd0, rt, 16'($urandom_range(0, 255) * 4));
        7:       imem[k] = enc_i(SW, 5'd0, rt, 16'($urandom_range(0, 255) * 4));
        8:       imem[k] = enc_i($urandom_range(0, 1) ? BEQ : BNE, rs, rt,
                                 16'($urandom_range(0, 3)));
        default: imem[k] = {bad_ops[$urandom_range(0, 5)], 26'($urandom)};
      endcase
    end
    reset_release();
    applyStimulus(150);

    // Asynchronous reset in the middle of the run, then dump every register.
    reset_assert();
    for (int k = 0; k < 32; k++) imem[k] = enc_i(SW, 5'd0, 5'(k), 16'(4*k));
    reset_release();
    applyStimulus(32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
